// File: rtl/laser_pkg.sv
// Shared types and bit-timing helpers for the laser link, used by the
// transmit clock divider and the receive bit sampler.
package laser_pkg;

  localparam int unsigned PHASE_W = 9;
  localparam int unsigned DIV_W   = 8;

  typedef enum logic {IDLE, TRACK} rx_state_t;

  // Half bit period in cycles: divider+1, carried at PHASE_W so 255 -> 256 fits.
  function automatic logic [PHASE_W-1:0] half_period(input logic [DIV_W-1:0] divider);
    return PHASE_W'(divider) + PHASE_W'(1);
  endfunction

  // Last phase index of a full bit period: 2*(divider+1)-1 == {divider, 1}.
  function automatic logic [PHASE_W-1:0] period_max(input logic [DIV_W-1:0] divider);
    return {divider, 1'b1};
  endfunction

endpackage

// File: rtl/laser_sync_edge.sv
// rx_in synchronizer and transition detector for the bit sampler.
// Optional LASER_GLITCH_FILTER_EN requires a new level to hold two cycles.
module laser_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic rx_in,
  output logic s,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx_in};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

`ifdef LASER_GLITCH_FILTER_EN
  // s_dd holds the last accepted level, so a one-cycle pulse returning to it
  // never satisfies s_d != s_dd once it has settled again.
  logic s_dd_q, s_dd_d;

  always_comb begin
    edge_det = (s == s_dly_q) && (s_dly_q != s_dd_q);
    s_dd_d   = edge_det ? s_dly_q : s_dd_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) s_dd_q <= 1'b0;
    else       s_dd_q <= s_dd_d;
  end
`else
  always_comb begin
    edge_det = (s != s_dly_q);
  end
`endif

endmodule

// File: rtl/laser_bit_sampler.sv
// Receive bit sampler: re-phases a local bit counter on every data transition
// and strobes one mid-bit sample per period; drops lock after MAX_RUN idle periods.
module laser_bit_sampler
  import laser_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_RUN     = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] divider,
  input  logic             rx_in,
  output logic             rx_bit,
  output logic             bit_valid,
  output logic             locked,
  output logic             lock_lost
);

  localparam logic [7:0] RUN_LAST = 8'(MAX_RUN - 1);

  logic s, edge_det;

  laser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx_in    (rx_in),
    .s        (s),
    .edge_det (edge_det)
  );

  rx_state_t           state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  half_q, half_d;
  logic [PHASE_W-1:0]  pmax_q, pmax_d;
  logic [7:0]          run_q, run_d;
  logic                rx_bit_q, rx_bit_d;
  logic                bit_valid_q, bit_valid_d;
  logic                locked_q, locked_d;
  logic                lock_lost_q, lock_lost_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    half_d      = half_q;
    pmax_d      = pmax_q;
    run_d       = run_q;
    rx_bit_d    = rx_bit_q;
    bit_valid_d = 1'b0;
    locked_d    = locked_q;
    lock_lost_d = 1'b0;

    if (!en) begin
      state_d  = IDLE;
      phase_d  = '0;
      run_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          locked_d = 1'b0;
          if (edge_det) begin
            state_d  = TRACK;
            phase_d  = '0;
            run_d    = '0;
            locked_d = 1'b1;
            half_d   = half_period(divider);
            pmax_d   = period_max(divider);
          end
        end
        TRACK: begin
          // A transition re-phases the counter and suppresses any coincident sample.
          if (edge_det) begin
            phase_d = '0;
            run_d   = '0;
          end else begin
            if (phase_q == half_q) begin
              rx_bit_d    = s;
              bit_valid_d = 1'b1;
            end
            if (phase_q == pmax_q) begin
              phase_d = '0;
              if (run_q == RUN_LAST) begin
                state_d     = IDLE;
                locked_d    = 1'b0;
                lock_lost_d = 1'b1;
                run_d       = '0;
              end else begin
                run_d = run_q + 1'b1;
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      half_q      <= '0;
      pmax_q      <= '0;
      run_q       <= '0;
      rx_bit_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      pmax_q      <= pmax_d;
      run_q       <= run_d;
      rx_bit_q    <= rx_bit_d;
      bit_valid_q <= bit_valid_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    rx_bit    = rx_bit_q;
    bit_valid = bit_valid_q;
    locked    = locked_q;
    lock_lost = lock_lost_q;
  end

endmodule

// File: tb/tb_laser_bit_sampler.sv
// Self-checking bench for laser_bit_sampler: table-driven bit patterns from a
// reference transmitter plus hand-written timeout/enable/reset/divider sequences.
`timescale 1ns/1ps
module tb_laser_bit_sampler;

  localparam int SYNC = 2;
`ifdef LASER_GLITCH_FILTER_EN
  localparam int GF = 1;
`else
  localparam int GF = 0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b0;
  logic       rx_in    = 1'b0;
  logic [7:0] divider  = 8'd0;
  logic       rx_bit, bit_valid, locked, lock_lost;

  laser_bit_sampler #(.SYNC_STAGES(SYNC), .MAX_RUN(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .en        (en),
    .divider   (divider),
    .rx_in     (rx_in),
    .rx_bit    (rx_bit),
    .bit_valid (bit_valid),
    .locked    (locked),
    .lock_lost (lock_lost)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct { int cyc; logic b; } exp_t;
  typedef struct { int div; logic init; int n; logic [7:0] pat; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lost_cnt = 0;
  int   lost_cyc = -1;
  logic prev_bv  = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_strobe(input int c, input logic b);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  function automatic int lat(input int div);
    return SYNC + GF + div + 3;
  endfunction

  // Scoreboard: every strobe must match the next expected (cycle, bit).
  always @(negedge CLOCK_50) begin
    if (reset) begin
      prev_bv = 1'b0;
    end else begin
      if (bit_valid) begin
        exp_t e;
        check("bit_valid_back_to_back", int'(prev_bv), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_bit", int'(rx_bit), int'(e.b));
        end
      end
      if (lock_lost) begin
        lost_cnt++;
        lost_cyc = cyc;
      end
      prev_bv = bit_valid;
    end
  end

  task automatic setup(input int div, input logic lvl);
    en      = 1'b0;
    rx_in   = lvl;
    divider = 8'(div);
    tick(6);
    en = 1'b1;
    tick(2);
  endtask

  task automatic run_pattern(input vec_t v);
    int p, c0, kc, last;
    p = 2 * (v.div + 1);
    setup(v.div, v.init);
    c0   = cyc;
    kc   = c0 + SYNC + GF;
    last = c0 + (v.n - 1) * p + lat(v.div);
    for (int i = 0; i < v.n; i++) expect_strobe(c0 + i * p + lat(v.div), v.pat[i]);
    for (int t = 0; t < v.n * p; t++) begin
      if (t % p == 0) rx_in = v.pat[t / p];
      tick(1);
      if (cyc == kc)     check("pre_lock", int'(locked), 0);
      if (cyc == kc + 1) check("locked_after_edge", int'(locked), 1);
    end
    while (cyc < last + 1) tick(1);
    en = 1'b0;
    tick(2);
    check("en_drop_unlocks", int'(locked), 0);
    check("pattern_strobes_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int c0, c1, lost0;
    vecs[0] = '{div: 3, init: 1'b0, n: 5, pat: 8'b0000_1101};
    vecs[1] = '{div: 1, init: 1'b0, n: 6, pat: 8'b0000_1011};
    vecs[2] = '{div: 0, init: 1'b1, n: 4, pat: 8'b0000_0000};
    vecs[3] = '{div: 7, init: 1'b0, n: 4, pat: 8'b0000_1001};
    vecs[4] = '{div: 2, init: 1'b1, n: 5, pat: 8'b0001_0110};

    tick(3);
    check("reset_rx_bit", int'(rx_bit), 0);
    check("reset_bit_valid", int'(bit_valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_lock_lost", int'(lock_lost), 0);
    reset = 1'b0;
    tick(3);
    check("idle_locked", int'(locked), 0);

    for (int i = 0; i < 5; i++) run_pattern(vecs[i]);

    // Run timeout: divider=1, one edge, then a constant line.
    setup(1, 1'b0);
    c0    = cyc;
    lost0 = lost_cnt;
    for (int i = 0; i < 8; i++) expect_strobe(c0 + lat(1) + 4 * i, 1'b1);
    rx_in = 1'b1;
    while (cyc < c0 + SYNC + GF + 33 + 2) tick(1);
    check("timeout_lost_pulses", lost_cnt - lost0, 1);
    check("timeout_lost_cycle", lost_cyc, c0 + SYNC + GF + 33);
    check("timeout_unlocked", int'(locked), 0);
    tick(20);
    check("timeout_strobes_missing", exp_q.size(), 0);
    check("timeout_single_pulse", lost_cnt - lost0, 1);
    exp_q.delete();

    // Edge exactly at the sample point.
    setup(3, 1'b0);
    c0 = cyc;
    expect_strobe(c0 + 5 + lat(3), 1'b0);
    rx_in = 1'b1;
    tick(5);
    rx_in = 1'b0;
    tick(2 + GF);
    check("edge_beats_sample", int'(bit_valid), 0);
    while (cyc < c0 + 5 + lat(3) + 1) tick(1);
    en = 1'b0;
    tick(2);
    check("sample_point_strobes_missing", exp_q.size(), 0);
    exp_q.delete();

    // Enable dropped in the cycle a strobe would register.
    setup(3, 1'b0);
    c0 = cyc;
    expect_strobe(c0 + lat(3), 1'b1);
    rx_in = 1'b1;
    while (cyc < c0 + lat(3) + 7) tick(1);
    check("locked_before_en_drop", int'(locked), 1);
    en = 1'b0;
    tick(1);
    check("en_drop_locked", int'(locked), 0);
    check("en_drop_bit_valid", int'(bit_valid), 0);
    check("en_drop_lock_lost", int'(lock_lost), 0);
    check("en_drop_rx_bit_held", int'(rx_bit), 1);
    tick(10);
    check("en_drop_strobes_missing", exp_q.size(), 0);
    exp_q.delete();

    // Divider change while tracking is ignored until re-lock.
    setup(3, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 3; i++) expect_strobe(c0 + lat(3) + 8 * i, 1'b1);
    rx_in = 1'b1;
    tick(10);
    divider = 8'd7;
    while (cyc < c0 + lat(3) + 17) tick(1);
    en = 1'b0;
    tick(2);
    check("div_change_old_period", exp_q.size(), 0);
    exp_q.delete();
    setup(7, 1'b1);
    c1 = cyc;
    expect_strobe(c1 + lat(7), 1'b0);
    expect_strobe(c1 + lat(7) + 16, 1'b0);
    rx_in = 1'b0;
    while (cyc < c1 + lat(7) + 17) tick(1);
    en = 1'b0;
    tick(2);
    check("div_change_new_period", exp_q.size(), 0);
    exp_q.delete();

    // Asynchronous reset mid-bit.
    setup(3, 1'b0);
    c0 = cyc;
    expect_strobe(c0 + lat(3), 1'b1);
    rx_in = 1'b1;
    while (cyc < c0 + lat(3) + 3) tick(1);
    check("pre_reset_locked", int'(locked), 1);
    check("pre_reset_rx_bit", int'(rx_bit), 1);
    #3 reset = 1'b1;
    #1;
    check("mid_reset_rx_bit", int'(rx_bit), 0);
    check("mid_reset_bit_valid", int'(bit_valid), 0);
    check("mid_reset_locked", int'(locked), 0);
    check("mid_reset_lock_lost", int'(lock_lost), 0);
    exp_q.delete();
    en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

`ifdef LASER_GLITCH_FILTER_EN
    // A one-cycle pulse must not lock.
    setup(3, 1'b0);
    rx_in = 1'b1;
    tick(1);
    rx_in = 1'b0;
    tick(12);
    check("glitch_ignored", int'(locked), 0);
    en = 1'b0;
    tick(2);
`endif

    check("lock_lost_total", lost_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
